// File: rtl/snake_pkg.sv
// Shared types and PS/2 set-2 scancode constants for the snake game input path.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Keyboard-byte input, command-queue handshake and event outputs of ps2_dir_decoder.
interface ps2_dir_decoder_if;
    logic [15:0] keycode;
    logic        oflag;
    logic        cmd_pop;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        start_pulse;
    logic        pause_pulse;
    logic        overflow;

    modport master (
        output keycode, oflag, cmd_pop,
        input  cmd_valid, cmd_dir, start_pulse, pause_pulse, overflow
    );

    modport slave (
        input  keycode, oflag, cmd_pop,
        output cmd_valid, cmd_dir, start_pulse, pause_pulse, overflow
    );
endinterface

// File: rtl/dir_fifo.sv
// Small 2-bit direction queue; DEPTH must be a power of two so pointers wrap naturally.
module dir_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [1:0] din,
    input  logic       pop,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full queue still accepts push+pop.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 scancode parser feeding a filtered direction queue plus start/pause pulses.
// Define PS2_WASD_EN to also accept W/D/S/A as up/right/down/left.
module ps2_dir_decoder
    import snake_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    ps2_dir_decoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [7:0] byte_in;
    logic       keycode_hi_unused;
    logic       is_make;
    logic       is_ext_make;
    logic       is_brk;

    dir_t       dec_dir;
    logic       dec_valid;
    dir_t       last_dir;
    logic       want_push;
    logic       push_ok;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_dout;

    logic       held_enter;
    logic       held_space;
    logic       start_pulse;
    logic       pause_pulse;
    logic       overflow;

    assign byte_in           = bus.keycode[7:0];
    assign keycode_hi_unused = ^bus.keycode[15:8];

    always_comb begin
        state_nx    = state;
        is_make     = 1'b0;
        is_ext_make = 1'b0;
        is_brk      = 1'b0;
        if (bus.oflag) begin
            case (state)
                ST_IDLE: begin
                    if (byte_in == SC_E0)      state_nx = ST_EXT;
                    else if (byte_in == SC_F0) state_nx = ST_BRK;
                    else                       is_make  = 1'b1;
                end
                ST_EXT: begin
                    if (byte_in == SC_F0) state_nx = ST_EXT_BRK;
                    else begin
                        is_ext_make = 1'b1;
                        state_nx    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_brk   = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dec_valid = 1'b0;
        dec_dir   = DIR_UP;
        if (is_ext_make) begin
            case (byte_in)
                SC_UP:    begin dec_valid = 1'b1; dec_dir = DIR_UP;    end
                SC_RIGHT: begin dec_valid = 1'b1; dec_dir = DIR_RIGHT; end
                SC_DOWN:  begin dec_valid = 1'b1; dec_dir = DIR_DOWN;  end
                SC_LEFT:  begin dec_valid = 1'b1; dec_dir = DIR_LEFT;  end
                default:  ;
            endcase
        end
`ifdef PS2_WASD_EN
        if (is_make) begin
            case (byte_in)
                SC_W:    begin dec_valid = 1'b1; dec_dir = DIR_UP;    end
                SC_D:    begin dec_valid = 1'b1; dec_dir = DIR_RIGHT; end
                SC_S:    begin dec_valid = 1'b1; dec_dir = DIR_DOWN;  end
                SC_A:    begin dec_valid = 1'b1; dec_dir = DIR_LEFT;  end
                default: ;
            endcase
        end
`endif
    end

    // Repeats and reversals relative to the last queued move are discarded.
    assign want_push = dec_valid && (dec_dir != last_dir) && (dec_dir != opposite(last_dir));
    assign push_ok   = want_push && (!fifo_full || (bus.cmd_pop && !fifo_empty));

    dir_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (want_push),
        .din   (dec_dir),
        .pop   (bus.cmd_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_dir    <= DIR_RIGHT;
            held_enter  <= 1'b0;
            held_space  <= 1'b0;
            start_pulse <= 1'b0;
            pause_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nx;
            start_pulse <= is_make && (byte_in == SC_ENTER) && !held_enter;
            pause_pulse <= is_make && (byte_in == SC_SPACE) && !held_space;
            if (is_make && byte_in == SC_ENTER)     held_enter <= 1'b1;
            else if (is_brk && byte_in == SC_ENTER) held_enter <= 1'b0;
            if (is_make && byte_in == SC_SPACE)     held_space <= 1'b1;
            else if (is_brk && byte_in == SC_SPACE) held_space <= 1'b0;
            if (push_ok)              last_dir <= dec_dir;
            if (want_push && !push_ok) overflow <= 1'b1;
        end
    end

    assign bus.cmd_valid   = !fifo_empty;
    assign bus.cmd_dir     = fifo_dout;
    assign bus.start_pulse = start_pulse;
    assign bus.pause_pulse = pause_pulse;
    assign bus.overflow    = overflow;
endmodule

// File: doc/ps2_dir_decoder.md
PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of queued direction commands; power of two, 2..16.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: keycode  input  16  {previous byte, current byte} from the PS/2 receiver; only bits [7:0] are used.
REQ-005 Port: oflag  input  1  one-cycle strobe; keycode[7:0] holds a new scancode byte.
REQ-006 Port: cmd_pop  input  1  consumer (game tick) removes the head command.
REQ-007 Port: cmd_valid  output  1  queue not empty.
REQ-008 Port: cmd_dir  output  2  head direction: 00 up, 01 right, 10 down, 11 left.
REQ-009 Port: start_pulse  output  1  one-cycle pulse on an Enter make.
REQ-010 Port: pause_pulse  output  1  one-cycle pulse on a Space make.
REQ-011 Port: overflow  output  1  sticky; a direction was dropped because the queue was full.

Function
REQ-012 The byte parser shall be an FSM with states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0), advancing only on oflag.
REQ-013 Transitions: IDLE --E0--> EXT; IDLE --F0--> BRK; EXT --F0--> EXT_BRK; any other byte completes a make (IDLE/EXT) or a break (BRK/EXT_BRK), and the FSM returns to IDLE.
REQ-014 Extended makes shall map E0 75 to up, E0 74 to right, E0 72 to down and E0 6B to left; non-extended makes 5A (Enter) and 29 (Space) shall map to start and pause; all other codes shall be ignored.
REQ-015 A held Space or Enter (typematic repeat) shall pulse only once; the per-key held flag shall set on make and clear on its break.
REQ-016 Direction repeats are not filtered by a held flag; REQ-017 handles them.
REQ-017 A decoded direction d shall be enqueued only if d != ref and d != (ref XOR 2'b10), where ref is the last enqueued direction, otherwise it shall be dropped silently.
REQ-018 ref shall reset to right (01) and update only on a successful enqueue; pops do not change it.
REQ-019 Latency: oflag in cycle N with a completing byte gives cmd_valid/cmd_dir, or the pulse, in cycle N+1.
REQ-020 cmd_pop while cmd_valid=0 shall be ignored.
REQ-021 A push to a full queue without a simultaneous pop shall be dropped, set overflow, and leave ref unchanged.
REQ-022 A simultaneous push and pop shall both occur, including when the queue is full; when the queue is empty, the pop is ignored and the push proceeds.
REQ-023 Read and write pointers shall wrap modulo FIFO_DEPTH, with occupancy tracked by a count of width clog2(FIFO_DEPTH)+1.
REQ-024 cmd_dir shall come directly from the head storage entry (registered), with no combinational path from keycode.

Reset
REQ-025 Reset shall force: FSM to IDLE, queue empty (cmd_valid=0), cmd_dir=00, ref=01, held flags=0, start_pulse=0, pause_pulse=0, overflow=0.
REQ-026 Reset asserted mid-sequence (for example after E0) shall discard the partial sequence; the next byte is parsed from IDLE.
REQ-027 Reset is the only way to clear overflow.

Configuration
REQ-028 Macro PS2_WASD_EN: when defined, non-extended makes 1D/23/1B/1C (W/D/S/A) shall also map to up/right/down/left under REQ-017; when undefined, these codes shall be ignored.

Structure
REQ-029 The shared package snake_pkg shall hold the direction type and encodings, the E0/F0 prefixes, and all scancode constants.
REQ-030 The queue shall be the sub-module dir_fifo (parameter DEPTH, width 2, push/pop/full/empty); the parser, filter and pulses stay in the top level.

Verification
REQ-031 The bench shall send bytes E0,75 with one-cycle oflag strobes 20 cycles apart, then expect cmd_valid=1 and cmd_dir=00 in the cycle after the 75 strobe, and ref=00.
REQ-032 From reset, the bench shall send E0 6B (left, opposite of ref=right) and E0 74 (same as ref), then expect no enqueue.
REQ-033 The bench shall send the sequence up, left, down, right with no pops and FIFO_DEPTH=4, then send up, and expect the 5th to be dropped, overflow=1, and pops to return 00,11,10,01.
REQ-034 The bench shall send 29,29,29 (typematic), then F0 29, then 29, and expect exactly two pause_pulse pulses; E0 F0 75 shall produce no command.
REQ-035 The bench shall send E0, assert reset for 1 cycle, then send 75, and expect no command (75 is an unmapped non-extended make).
REQ-036 With a full queue, the bench shall apply push and cmd_pop in the same cycle, and expect the count to stay 4, overflow to stay 0, and the head to advance.
REQ-037 With PS2_WASD_EN defined, the bench shall send 1D and expect cmd_dir=00; with the macro undefined, the bench shall expect no command.
